// File: rtl/alu_pkg.sv
// Shared definitions for the ALU request path: opcode constants, legality check
// and the issue-sequencer state encoding.
package alu_pkg;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic is_legal_op(input logic [2:0] op);
        case (op)
            OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT: is_legal_op = 1'b1;
            default:                               is_legal_op = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_req_fifo.sv
// Synchronous FIFO of packed {opcode, a, b} requests; head entry is visible
// combinationally on pop_data.
module alu_req_fifo #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 push,
    input  logic [3+2*WIDTH-1:0] push_data,
    input  logic                 pop,
    output logic [3+2*WIDTH-1:0] pop_data,
    output logic                 full,
    output logic                 empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned EW = 3 + 2*WIDTH;

    logic [EW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          do_push;
    logic          do_pop;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;
    assign pop_data = mem[rd_ptr];

    // Storage needs no reset; only pointers and occupancy define validity.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/alu_issue_queue.sv
// Queues ALU requests, issues them one at a time on registered alu_* lines and
// holds each captured result on a valid/ready output port.
module alu_issue_queue
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_opcode,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_opcode,
    input  logic [WIDTH-1:0] alu_f,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_zero,
    output logic             out_err,
    output logic [2:0]       out_opcode
);

    localparam int unsigned EW = 3 + 2*WIDTH;

    state_t           state;
    logic             push;
    logic             pop;
    logic             full;
    logic             empty;
    logic [EW-1:0]    head;
    logic [2:0]       head_op;
    logic [WIDTH-1:0] head_a;
    logic [WIDTH-1:0] head_b;
    logic [WIDTH-1:0] result_next;

    assign in_ready = ~full;
    assign push     = in_valid & in_ready;
    assign pop      = ~empty & ((state == IDLE) | ((state == DONE) & out_ready));
    assign {head_op, head_a, head_b} = head;

    // Illegal opcodes never forward whatever the ALU drives for them.
    assign result_next = is_legal_op(alu_opcode) ? alu_f : '0;

    alu_req_fifo #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .push_data({in_opcode, in_a, in_b}),
        .pop      (pop),
        .pop_data (head),
        .full     (full),
        .empty    (empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_opcode <= '0;
            out_valid  <= 1'b0;
            out_result <= '0;
            out_zero   <= 1'b0;
            out_err    <= 1'b0;
            out_opcode <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        alu_a      <= head_a;
                        alu_b      <= head_b;
                        alu_opcode <= head_op;
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    out_result <= result_next;
                    out_zero   <= (result_next == '0);
                    out_err    <= ~is_legal_op(alu_opcode);
                    out_opcode <= alu_opcode;
                    out_valid  <= 1'b1;
                    state      <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (pop) begin
                            alu_a      <= head_a;
                            alu_b      <= head_b;
                            alu_opcode <= head_op;
                            state      <= EXEC;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
